// File: rtl/uart_framed.sv
// uart_framed: full-duplex UART with build-time framing (5-8 data bits,
// none/even/odd parity, 1 or 2 stop bits) plus parity/framing error flags.
// Optional feature macro: UART_LOOPBACK_EN adds a 'loopback' input that routes
// the internal tx stream into the rx path and parks the tx pin high.
module uart_framed #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 115200,
    parameter int OVERSAMPLING  = 8,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       tx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err
`ifdef UART_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    localparam int ACC_W = $clog2(CLK_FREQUENCY / BAUD_RATE) + 8;
    localparam longint unsigned ACC_SPAN = 64'd1 << ACC_W;
    localparam longint unsigned CLK_L    = longint'(CLK_FREQUENCY);
    localparam longint unsigned TX_RATE  = longint'(BAUD_RATE);
    localparam longint unsigned RX_RATE  = longint'(BAUD_RATE) * longint'(OVERSAMPLING);
    localparam longint unsigned TX_INC_L = (TX_RATE * ACC_SPAN + CLK_L / 2) / CLK_L;
    localparam longint unsigned RX_INC_L = (RX_RATE * ACC_SPAN + CLK_L / 2) / CLK_L;
    localparam logic [ACC_W-1:0] TX_INC  = ACC_W'(TX_INC_L);
    localparam logic [ACC_W-1:0] RX_INC  = ACC_W'(RX_INC_L);

    localparam int CNT_W = $clog2(OVERSAMPLING);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLING - 1);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_DONE   = 3'd5;

    logic [2:0]           r_txState;
    logic [ACC_W-1:0]     r_txAcc;
    logic                 r_txTick;
    logic                 r_tx;
    logic                 r_txBusy;
    logic                 r_txDone;
    logic [DATA_BITS-1:0] r_txShift;
    logic                 r_txPar;
    logic [3:0]           r_txBitCnt;
    logic                 r_txStopCnt;
    logic [ACC_W:0]       w_txSum;

    logic [1:0]           r_sync;
    logic [1:0]           r_filtCnt;
    logic [1:0]           w_filtCntNext;
    logic                 r_rxFilt;
    logic                 w_lineIn;
    logic [ACC_W-1:0]     r_rxAcc;
    logic                 r_rxTick;
    logic [ACC_W:0]       w_rxSum;

    logic [2:0]           r_rxState;
    logic [CNT_W-1:0]     r_rxCnt;
    logic [3:0]           r_rxBitCnt;
    logic [DATA_BITS-1:0] r_rxShift;
    logic                 r_rxArmed;
    logic                 r_rxParMis;
    logic                 r_rxFrameBad;
    logic [7:0]           r_rxData;
    logic                 r_rxValid;
    logic                 r_rxParErr;
    logic                 r_rxFrameErr;

`ifdef UART_LOOPBACK_EN
    assign w_lineIn = loopback ? r_tx : rx;
    assign tx       = loopback ? 1'b1 : r_tx;
`else
    assign w_lineIn = rx;
    assign tx       = r_tx;
`endif

    assign tx_busy       = r_txBusy;
    assign tx_done       = r_txDone;
    assign rx_data       = r_rxData;
    assign rx_valid      = r_rxValid;
    assign rx_parity_err = r_rxParErr;
    assign rx_frame_err  = r_rxFrameErr;

    assign w_txSum = {1'b0, r_txAcc} + {1'b0, TX_INC};
    assign w_rxSum = {1'b0, r_rxAcc} + {1'b0, RX_INC};

    // Transmit side: baud accumulator (held preloaded while idle) and frame sequencer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_txState   <= TX_IDLE;
            r_txAcc     <= '0;
            r_txTick    <= 1'b0;
            r_tx        <= 1'b1;
            r_txBusy    <= 1'b0;
            r_txDone    <= 1'b0;
            r_txShift   <= '0;
            r_txPar     <= 1'b0;
            r_txBitCnt  <= '0;
            r_txStopCnt <= 1'b0;
        end else begin
            r_txDone <= 1'b0;
            if (r_txState == TX_IDLE) begin
                r_txAcc  <= TX_INC;
                r_txTick <= 1'b0;
            end else begin
                r_txAcc  <= w_txSum[ACC_W-1:0];
                r_txTick <= w_txSum[ACC_W];
            end
            case (r_txState)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_start && !r_txDone) begin
                        r_txShift <= tx_data[DATA_BITS-1:0];
                        r_txPar   <= (PARITY == 2) ? ~(^tx_data[DATA_BITS-1:0]) : ^tx_data[DATA_BITS-1:0];
                        r_txBusy  <= 1'b1;
                        r_tx      <= 1'b0;
                        r_txState <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_txTick) begin
                        r_tx       <= r_txShift[0];
                        r_txShift  <= r_txShift >> 1;
                        r_txBitCnt <= '0;
                        r_txState  <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (r_txTick) begin
                        if (r_txBitCnt == LAST_BIT) begin
                            if (PARITY != 0) begin
                                r_tx      <= r_txPar;
                                r_txState <= TX_PARITY;
                            end else begin
                                r_tx        <= 1'b1;
                                r_txStopCnt <= 1'b0;
                                r_txState   <= TX_STOP;
                            end
                        end else begin
                            r_tx       <= r_txShift[0];
                            r_txShift  <= r_txShift >> 1;
                            r_txBitCnt <= r_txBitCnt + 4'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (r_txTick) begin
                        r_tx        <= 1'b1;
                        r_txStopCnt <= 1'b0;
                        r_txState   <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (r_txTick) begin
                        if (r_txStopCnt == LAST_STOP) begin
                            r_txBusy  <= 1'b0;
                            r_txDone  <= 1'b1;
                            r_txState <= TX_IDLE;
                        end else begin
                            r_txStopCnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx      <= 1'b1;
                    r_txBusy  <= 1'b0;
                    r_txState <= TX_IDLE;
                end
            endcase
        end
    end

    // Next value of the glitch-filter counter: walks toward the synchronised line level
    always_comb begin
        w_filtCntNext = r_filtCnt;
        if (r_sync[1] && (r_filtCnt != 2'd3)) begin
            w_filtCntNext = r_filtCnt + 2'd1;
        end else if (!r_sync[1] && (r_filtCnt != 2'd0)) begin
            w_filtCntNext = r_filtCnt - 2'd1;
        end
    end

    // Synchroniser and filter: the filtered level only flips when the counter saturates
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync    <= 2'b11;
            r_filtCnt <= 2'd3;
            r_rxFilt  <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], w_lineIn};
            r_filtCnt <= w_filtCntNext;
            if (w_filtCntNext == 2'd0) begin
                r_rxFilt <= 1'b0;
            end else if (w_filtCntNext == 2'd3) begin
                r_rxFilt <= 1'b1;
            end
        end
    end

    // Free-running oversampling tick for the receiver
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rxAcc  <= '0;
            r_rxTick <= 1'b0;
        end else begin
            r_rxAcc  <= w_rxSum[ACC_W-1:0];
            r_rxTick <= w_rxSum[ACC_W];
        end
    end

    // Receive sequencer: re-arms only after the line idles high, samples mid-bit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rxState    <= RX_IDLE;
            r_rxCnt      <= '0;
            r_rxBitCnt   <= '0;
            r_rxShift    <= '0;
            r_rxArmed    <= 1'b0;
            r_rxParMis   <= 1'b0;
            r_rxFrameBad <= 1'b0;
            r_rxData     <= '0;
            r_rxValid    <= 1'b0;
            r_rxParErr   <= 1'b0;
            r_rxFrameErr <= 1'b0;
        end else begin
            r_rxValid <= 1'b0;
            case (r_rxState)
                RX_IDLE: begin
                    if (r_rxFilt) begin
                        r_rxArmed <= 1'b1;
                    end
                    if (r_rxTick && r_rxArmed && !r_rxFilt) begin
                        r_rxArmed <= 1'b0;
                        r_rxCnt   <= '0;
                        r_rxState <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rxTick) begin
                        if (r_rxCnt == HALF_M1) begin
                            r_rxCnt    <= '0;
                            r_rxBitCnt <= '0;
                            r_rxState  <= r_rxFilt ? RX_IDLE : RX_DATA;
                        end else begin
                            r_rxCnt <= r_rxCnt + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (r_rxTick) begin
                        if (r_rxCnt == FULL_M1) begin
                            r_rxCnt   <= '0;
                            r_rxShift <= {r_rxFilt, r_rxShift[DATA_BITS-1:1]};
                            if (r_rxBitCnt == LAST_BIT) begin
                                r_rxState <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                            end else begin
                                r_rxBitCnt <= r_rxBitCnt + 4'd1;
                            end
                        end else begin
                            r_rxCnt <= r_rxCnt + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (r_rxTick) begin
                        if (r_rxCnt == FULL_M1) begin
                            r_rxCnt    <= '0;
                            r_rxParMis <= r_rxFilt ^ ((PARITY == 2) ? ~(^r_rxShift) : ^r_rxShift);
                            r_rxState  <= RX_STOP;
                        end else begin
                            r_rxCnt <= r_rxCnt + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (r_rxTick) begin
                        if (r_rxCnt == FULL_M1) begin
                            r_rxCnt      <= '0;
                            r_rxFrameBad <= ~r_rxFilt;
                            r_rxState    <= RX_DONE;
                        end else begin
                            r_rxCnt <= r_rxCnt + 1'b1;
                        end
                    end
                end
                RX_DONE: begin
                    if (r_rxTick) begin
                        r_rxData     <= 8'(r_rxShift);
                        r_rxParErr   <= r_rxParMis;
                        r_rxFrameErr <= r_rxFrameBad;
                        r_rxValid    <= 1'b1;
                        r_rxState    <= RX_IDLE;
                    end
                end
                default: begin
                    r_rxState <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_framed.sv
// tb_uart_framed: scoreboard bench for uart_framed at 16 clk per bit.
// Three instances: 8N1 (tx checks, rx from bench), 7E2 (tx wired to its own rx),
// 8O1 (rx from bench). Define UART_LOOPBACK_EN to also exercise the loopback port.
module tb_uart_framed;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rxExp_t;

    logic clk;
    logic reset_n;

    logic       rxLine8n1, tx8n1, txStart8n1, busy8n1, done8n1, valid8n1, perr8n1, ferr8n1;
    logic [7:0] txData8n1, rxData8n1;
    logic       tx7e2, txStart7e2, busy7e2, done7e2, valid7e2, perr7e2, ferr7e2;
    logic [7:0] txData7e2, rxData7e2;
    logic       rxLine8o1, tx8o1, txStart8o1, busy8o1, done8o1, valid8o1, perr8o1, ferr8o1;
    logic [7:0] txData8o1, rxData8o1;
    logic       loopbackSel;

    rxExp_t q8n1[$];
    rxExp_t q7e2[$];
    rxExp_t q8o1[$];
    rxExp_t e8n1, e7e2, e8o1;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_framed #(.CLK_FREQUENCY(1000000), .BAUD_RATE(62500), .OVERSAMPLING(8),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8n1 (
        .clk(clk), .reset_n(reset_n), .rx(rxLine8n1), .tx(tx8n1),
        .tx_start(txStart8n1), .tx_data(txData8n1), .tx_busy(busy8n1), .tx_done(done8n1),
        .rx_data(rxData8n1), .rx_valid(valid8n1), .rx_parity_err(perr8n1), .rx_frame_err(ferr8n1)
`ifdef UART_LOOPBACK_EN
        , .loopback(loopbackSel)
`endif
    );

    uart_framed #(.CLK_FREQUENCY(1000000), .BAUD_RATE(62500), .OVERSAMPLING(8),
                  .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u7e2 (
        .clk(clk), .reset_n(reset_n), .rx(tx7e2), .tx(tx7e2),
        .tx_start(txStart7e2), .tx_data(txData7e2), .tx_busy(busy7e2), .tx_done(done7e2),
        .rx_data(rxData7e2), .rx_valid(valid7e2), .rx_parity_err(perr7e2), .rx_frame_err(ferr7e2)
`ifdef UART_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );

    uart_framed #(.CLK_FREQUENCY(1000000), .BAUD_RATE(62500), .OVERSAMPLING(8),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u8o1 (
        .clk(clk), .reset_n(reset_n), .rx(rxLine8o1), .tx(tx8o1),
        .tx_start(txStart8o1), .tx_data(txData8o1), .tx_busy(busy8o1), .tx_done(done8o1),
        .rx_data(rxData8o1), .rx_valid(valid8o1), .rx_parity_err(perr8o1), .rx_frame_err(ferr8o1)
`ifdef UART_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );

    // Compare one observed value against the bench's expectation and tally the result
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive a serial frame (bit 0 first) onto a bench-owned rx line, 16 clk per bit
    task automatic applyStimulus(input int which, input logic [15:0] bits, input int nBits);
        for (int i = 0; i < nBits; i++) begin
            if (which == 0) rxLine8n1 = bits[i];
            else            rxLine8o1 = bits[i];
            repeat (16) @(negedge clk);
        end
        rxLine8n1 = 1'b1;
        rxLine8o1 = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    // Send one frame from the 8N1 (which=0) or 7E2 (which=1) instance and check the line
    task automatic runTx(input int which, input logic [7:0] data, input logic [11:0] expFrame,
                         input int nBits, input int abortAt);
        int busyCnt;
        int doneCnt;
        int doneAt;
        bit aborted;
        logic curTx, curBusy, curDone;
        string tag;
        tag = (which == 0) ? "8n1" : "7e2";
        busyCnt = 0;
        doneCnt = 0;
        doneAt  = 0;
        aborted = 1'b0;
        @(negedge clk);
        if (which == 0) begin txData8n1 = data; txStart8n1 = 1'b1; end
        else            begin txData7e2 = data; txStart7e2 = 1'b1; end
        for (int c = 1; c <= nBits * 16 + 20; c++) begin
            @(negedge clk);
            txStart8n1 = 1'b0;
            txStart7e2 = 1'b0;
            if (abortAt != 0 && c == abortAt) begin
                reset_n = 1'b0;
                @(negedge clk);
                curTx   = (which == 0) ? tx8n1 : tx7e2;
                curBusy = (which == 0) ? busy8n1 : busy7e2;
                checkOutput({tag, " tx after reset"}, 32'(curTx), 32'd1);
                checkOutput({tag, " busy after reset"}, 32'(curBusy), 32'd0);
                reset_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            curTx   = (which == 0) ? tx8n1 : tx7e2;
            curBusy = (which == 0) ? busy8n1 : busy7e2;
            curDone = (which == 0) ? done8n1 : done7e2;
            if (curBusy === 1'b1) busyCnt++;
            if (curDone === 1'b1) begin doneCnt++; doneAt = c; end
            if ((c % 16) == 9 && c <= nBits * 16)
                checkOutput($sformatf("%s tx bit %0d", tag, c / 16), 32'(curTx), 32'(expFrame[c / 16]));
        end
        if (!aborted) begin
            checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'(nBits * 16));
            checkOutput({tag, " done pulses"}, 32'(doneCnt), 32'd1);
            checkOutput({tag, " done timing"}, 32'(doneAt), 32'(nBits * 16 + 1));
        end
        repeat (8) @(negedge clk);
    endtask

    // Scoreboard monitor for the 8N1 receiver
    always @(negedge clk) begin
        if (valid8n1 === 1'b1) begin
            if (q8n1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL 8n1 unexpected rx_valid: got data 0x%0h, expected no frame", rxData8n1);
            end else begin
                e8n1 = q8n1.pop_front();
                checkOutput("8n1 rx_data", 32'(rxData8n1), 32'(e8n1.data));
                checkOutput("8n1 parity_err", 32'(perr8n1), 32'(e8n1.perr));
                checkOutput("8n1 frame_err", 32'(ferr8n1), 32'(e8n1.ferr));
            end
        end
    end

    // Scoreboard monitor for the 7E2 self-loop receiver
    always @(negedge clk) begin
        if (valid7e2 === 1'b1) begin
            if (q7e2.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL 7e2 unexpected rx_valid: got data 0x%0h, expected no frame", rxData7e2);
            end else begin
                e7e2 = q7e2.pop_front();
                checkOutput("7e2 rx_data", 32'(rxData7e2), 32'(e7e2.data));
                checkOutput("7e2 parity_err", 32'(perr7e2), 32'(e7e2.perr));
                checkOutput("7e2 frame_err", 32'(ferr7e2), 32'(e7e2.ferr));
            end
        end
    end

    // Scoreboard monitor for the 8O1 receiver
    always @(negedge clk) begin
        if (valid8o1 === 1'b1) begin
            if (q8o1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL 8o1 unexpected rx_valid: got data 0x%0h, expected no frame", rxData8o1);
            end else begin
                e8o1 = q8o1.pop_front();
                checkOutput("8o1 rx_data", 32'(rxData8o1), 32'(e8o1.data));
                checkOutput("8o1 parity_err", 32'(perr8o1), 32'(e8o1.perr));
                checkOutput("8o1 frame_err", 32'(ferr8o1), 32'(e8o1.ferr));
            end
        end
    end

    // Directed test sequence
    initial begin
        int lowCnt;
        reset_n     = 1'b0;
        rxLine8n1   = 1'b1;
        rxLine8o1   = 1'b1;
        txStart8n1  = 1'b0;
        txStart7e2  = 1'b0;
        txStart8o1  = 1'b0;
        txData8n1   = 8'h00;
        txData7e2   = 8'h00;
        txData8o1   = 8'h00;
        loopbackSel = 1'b0;
        lowCnt      = 0;
        repeat (4) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset tx", 32'(tx8n1), 32'd1);
        checkOutput("reset tx_busy", 32'(busy8n1), 32'd0);
        checkOutput("reset tx_done", 32'(done8n1), 32'd0);
        checkOutput("reset rx_data", 32'(rxData8n1), 32'd0);
        checkOutput("reset rx_valid", 32'(valid8n1), 32'd0);
        checkOutput("reset parity_err", 32'(perr8n1), 32'd0);
        checkOutput("reset frame_err", 32'(ferr8n1), 32'd0);
        checkOutput("reset 7e2 tx", 32'(tx7e2), 32'd1);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] 8N1 transmit 0xA5");
        runTx(0, 8'hA5, 12'b00_1101001010, 10, 0);

        $display("[TB] reset during data bit 3, then 0x3C");
        runTx(0, 8'hA5, 12'b00_1101001010, 10, 70);
        repeat (10) @(negedge clk);
        runTx(0, 8'h3C, 12'b00_1001111000, 10, 0);

        $display("[TB] 7E2 self loop 0x55");
        q7e2.push_back(rxExp_t'{8'h55, 1'b0, 1'b0});
        runTx(1, 8'h55, {2'b11, 1'b0, 7'h55, 1'b0}, 11, 0);
        repeat (40) @(negedge clk);
        checkOutput("7e2 frames drained", 32'(q7e2.size()), 32'd0);

        $display("[TB] 8O1 receive with parity error then good frames");
        q8o1.push_back(rxExp_t'{8'h0F, 1'b1, 1'b0});
        applyStimulus(1, {5'b0, 1'b1, 1'b0, 8'h0F, 1'b0}, 11);
        q8o1.push_back(rxExp_t'{8'h81, 1'b0, 1'b0});
        applyStimulus(1, {5'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 11);
        q8o1.push_back(rxExp_t'{8'h07, 1'b0, 1'b0});
        applyStimulus(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (20) @(negedge clk);
        checkOutput("8o1 frames drained", 32'(q8o1.size()), 32'd0);

        $display("[TB] glitch and false start on 8N1 rx");
        rxLine8n1 = 1'b0;
        repeat (2) @(negedge clk);
        rxLine8n1 = 1'b1;
        repeat (60) @(negedge clk);
        rxLine8n1 = 1'b0;
        repeat (5) @(negedge clk);
        rxLine8n1 = 1'b1;
        repeat (200) @(negedge clk);
        q8n1.push_back(rxExp_t'{8'h5A, 1'b0, 1'b0});
        applyStimulus(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        checkOutput("8n1 frame after false start", 32'(q8n1.size()), 32'd0);

        $display("[TB] break on 8N1 rx");
        q8n1.push_back(rxExp_t'{8'h00, 1'b0, 1'b1});
        applyStimulus(0, 16'h0000, 12);
        repeat (250) @(negedge clk);
        checkOutput("8n1 break reported once", 32'(q8n1.size()), 32'd0);
        q8n1.push_back(rxExp_t'{8'h96, 1'b0, 1'b0});
        applyStimulus(0, {6'b0, 1'b1, 8'h96, 1'b0}, 10);
        checkOutput("8n1 frame after break", 32'(q8n1.size()), 32'd0);

`ifdef UART_LOOPBACK_EN
        $display("[TB] loopback 0xC3");
        q8n1.push_back(rxExp_t'{8'hC3, 1'b0, 1'b0});
        loopbackSel = 1'b1;
        repeat (10) @(negedge clk);
        txData8n1  = 8'hC3;
        txStart8n1 = 1'b1;
        @(negedge clk);
        txStart8n1 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx8n1 !== 1'b1) lowCnt++;
        end
        checkOutput("loopback pin tx low cycles", 32'(lowCnt), 32'd0);
        loopbackSel = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("loopback frame received", 32'(q8n1.size()), 32'd0);
`endif

        repeat (20) @(negedge clk);
        checkOutput("8n1 queue empty at end", 32'(q8n1.size()), 32'd0);
        checkOutput("7e2 queue empty at end", 32'(q7e2.size()), 32'd0);
        checkOutput("8o1 queue empty at end", 32'(q8o1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
